// File: rtl/s38584_capture_bank.sv
// Two-stage capture bank. It selects one source lane, registers it, and writes it
// into an addressed entry. The entries drain as a valid/ready stream.
module s38584_capture_bank #(
  parameter int unsigned     WIDTH  = 4,
  parameter int unsigned     NSRC   = 8,
  parameter int unsigned     DEPTH  = 4,
  parameter int unsigned     SEL_W  = 3,
  parameter int unsigned     ADDR_W = 2,
  parameter logic [WIDTH-1:0] DFLT  = '0
) (
  input  logic                    CK,
  input  logic                    RN,
  input  logic                    run,
  input  logic                    cap_valid,
  output logic                    cap_ready,
  input  logic [SEL_W-1:0]        cap_sel,
  input  logic [ADDR_W-1:0]       cap_addr,
  input  logic [NSRC*WIDTH-1:0]   src,
  input  logic                    drain_start,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [ADDR_W-1:0]       out_idx,
  output logic                    out_last,
  output logic                    busy,
  output logic [7:0]              err_cnt
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StFlush, StDrain} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]    entry_q [DEPTH];
  logic                s2_vld_q;
  logic                s2_inr_q;
  logic [WIDTH-1:0]    s2_data_q;
  logic [ADDR_W-1:0]   s2_addr_q;
  logic [7:0]          err_cnt_q;

  logic                accept;
  logic                sel_ok;
  logic [WIDTH-1:0]    lane_sel;

  // Lane mux; out-of-range selects yield zero and are flagged, never written.
  always_comb begin
    lane_sel = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (32'(cap_sel) == i) lane_sel = src[i*WIDTH +: WIDTH];
    end
    sel_ok = 32'(cap_sel) < NSRC;
  end

  // Capture handshake; reset is folded in so cap_ready stays low while RN is asserted.
  always_comb begin
    cap_ready = run & RN & (state_q == StIdle);
    accept    = cap_valid & cap_ready;
  end

  // Stage 1: accept register holding lane, address and range flag.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      s2_vld_q  <= 1'b0;
      s2_inr_q  <= 1'b0;
      s2_data_q <= '0;
      s2_addr_q <= '0;
    end else begin
      s2_vld_q <= accept;
      if (accept) begin
        s2_inr_q  <= sel_ok;
        s2_data_q <= lane_sel;
        s2_addr_q <= cap_addr;
      end
    end
  end

  // Stage 2: entry write. run=0 overrides everything, discarding any pending write.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      for (int unsigned i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else if (!run) begin
      for (int unsigned i = 0; i < DEPTH; i++) entry_q[i] <= DFLT;
    end else if (s2_vld_q && s2_inr_q) begin
      entry_q[s2_addr_q] <= s2_data_q;
    end
  end

  // Rejected-select counter. It saturates and holds while run=0.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      err_cnt_q <= '0;
    end else if (run && s2_vld_q && !s2_inr_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  // State and read pointer registers.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q  <= StIdle;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Next-state logic for the idle/flush/drain sequencer.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (drain_start) begin
          if (s2_vld_q || accept) begin
            state_d = StFlush;
          end else begin
            state_d  = StDrain;
            rd_ptr_d = '0;
          end
        end
      end
      StFlush: begin
        // No capture is accepted outside idle, so the pending write retires on this edge.
        if (!accept) begin
          state_d  = StDrain;
          rd_ptr_d = '0;
        end
      end
      StDrain: begin
        if (out_ready) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (rd_ptr_q == LastIdx) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Drain stream outputs. These are driven from registered state, so they hold while stalled.
  always_comb begin
    out_valid = (state_q == StDrain);
    out_data  = entry_q[rd_ptr_q];
    out_idx   = rd_ptr_q;
    out_last  = out_valid & (rd_ptr_q == LastIdx);
    busy      = (state_q != StIdle);
    err_cnt   = err_cnt_q;
  end

endmodule

// File: tb/tb_s38584_capture_bank.sv
// Self-checking bench: directed scenarios plus randomized captures and drains
// against an array-based model of the entry contents and error count.
module tb_s38584_capture_bank;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned NSRC   = 6;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned ADDR_W = 2;

  logic                  ck = 1'b0;
  logic                  rn = 1'b0;
  logic                  run = 1'b1;
  logic                  cap_valid = 1'b0;
  logic                  cap_ready;
  logic [SEL_W-1:0]      cap_sel = '0;
  logic [ADDR_W-1:0]     cap_addr = '0;
  logic [NSRC*WIDTH-1:0] src = '0;
  logic                  drain_start = 1'b0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [WIDTH-1:0]      out_data;
  logic [ADDR_W-1:0]     out_idx;
  logic                  out_last;
  logic                  busy;
  logic [7:0]            err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int model_mem [DEPTH];
  int model_err = 0;

  s38584_capture_bank #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC),
    .DEPTH (DEPTH),
    .SEL_W (SEL_W),
    .ADDR_W(ADDR_W),
    .DFLT  ('0)
  ) dut (
    .CK         (ck),
    .RN         (rn),
    .run        (run),
    .cap_valid  (cap_valid),
    .cap_ready  (cap_ready),
    .cap_sel    (cap_sel),
    .cap_addr   (cap_addr),
    .src        (src),
    .drain_start(drain_start),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  always #5 ck = ~ck;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic clear_model(input int err_too);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
    if (err_too != 0) model_err = 0;
  endtask

  function automatic logic [NSRC*WIDTH-1:0] rand_lanes();
    logic [31:0] r;
    r = $urandom;
    return r[NSRC*WIDTH-1:0];
  endfunction

  // Present one capture and hold it until it is accepted. The model is then updated.
  task automatic capture(input int sel, input int addr, input logic [NSRC*WIDTH-1:0] lanes);
    int budget;
    budget    = 50;
    cap_valid = 1'b1;
    cap_sel   = SEL_W'(sel);
    cap_addr  = ADDR_W'(addr);
    src       = lanes;
    while (!cap_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (!cap_ready) check_eq("cap_ready_wait", {31'd0, cap_ready}, 1);
    tick();
    cap_valid = 1'b0;
    if (sel < NSRC) model_mem[addr] = int'(lanes[sel*WIDTH +: WIDTH]);
    else if (model_err < 255) model_err++;
  endtask

  // mode 0: always ready, 1: ready toggles 1,0,1,..., 2: random ready.
  task automatic drain(input int start, input int mode);
    int   budget;
    int   tog;
    int   tries;
    logic r;
    tog = 0;
    if (start != 0) begin
      drain_start = 1'b1;
      tick();
      drain_start = 1'b0;
    end
    for (int k = 0; k < DEPTH; k++) begin
      budget = 20;
      while (!out_valid && budget > 0) begin
        tick();
        budget--;
      end
      check_eq("drain_valid", {31'd0, out_valid}, 1);
      check_eq("drain_idx", {30'd0, out_idx}, k);
      check_eq("drain_data", {28'd0, out_data}, model_mem[k]);
      check_eq("drain_last", {31'd0, out_last}, (k == DEPTH - 1) ? 1 : 0);
      tries = 0;
      do begin
        if (mode == 0 || tries > 8) r = 1'b1;
        else if (mode == 1) r = (tog % 2 == 0);
        else r = 1'($urandom_range(0, 1));
        tog++;
        tries++;
        out_ready = r;
        tick();
        if (!r) begin
          check_eq("stall_valid", {31'd0, out_valid}, 1);
          check_eq("stall_idx", {30'd0, out_idx}, k);
          check_eq("stall_data", {28'd0, out_data}, model_mem[k]);
        end
      end while (!r);
      out_ready = 1'b0;
    end
    check_eq("done_valid", {31'd0, out_valid}, 0);
    check_eq("done_busy", {31'd0, busy}, 0);
    check_eq("err_cnt", {24'd0, err_cnt}, model_err);
  endtask

  initial begin
    logic [NSRC*WIDTH-1:0] lanes;
    int                    choice;
    clear_model(1);

    // Reset state.
    #2;
    check_eq("rst_cap_ready", {31'd0, cap_ready}, 0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 0);
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_err", {24'd0, err_cnt}, 0);
    tick();
    tick();
    rn = 1'b1;
    #1;
    check_eq("post_rst_ready", {31'd0, cap_ready}, 1);

    // Single capture of lane 2 into entry 1.
    lanes = rand_lanes();
    lanes[2*WIDTH +: WIDTH] = 4'hA;
    capture(2, 1, lanes);
    drain(1, 0);

    // Four back-to-back captures, then a drain with toggling ready.
    lanes = rand_lanes();
    for (int i = 0; i < 4; i++) lanes[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
    for (int i = 0; i < 4; i++) capture(i, 3 - i, lanes);
    drain(1, 1);

    // Out-of-range selects saturate the error count and leave entries untouched.
    for (int i = 0; i < 300; i++) capture($urandom_range(NSRC, 7), $urandom_range(0, 3), rand_lanes());
    tick();
    tick();
    check_eq("err_sat", {24'd0, err_cnt}, 255);
    drain(1, 2);

    // Capture and drain_start collide: one flush cycle, then the new value is visible.
    lanes = rand_lanes();
    cap_valid   = 1'b1;
    cap_sel     = 3'd4;
    cap_addr    = 2'd0;
    src         = lanes;
    drain_start = 1'b1;
    check_eq("coll_ready", {31'd0, cap_ready}, 1);
    tick();
    cap_valid   = 1'b0;
    drain_start = 1'b0;
    model_mem[0] = int'(lanes[4*WIDTH +: WIDTH]);
    check_eq("flush_busy", {31'd0, busy}, 1);
    check_eq("flush_valid", {31'd0, out_valid}, 0);
    tick();
    check_eq("flush_done", {31'd0, out_valid}, 1);
    drain(0, 0);

    // run=0 for one cycle with a write pending wipes everything to the default.
    capture(1, 2, rand_lanes());
    run = 1'b0;
    #1;
    check_eq("run0_ready", {31'd0, cap_ready}, 0);
    tick();
    run = 1'b1;
    clear_model(0);
    #1;
    check_eq("run1_ready", {31'd0, cap_ready}, 1);
    drain(1, 0);

    // Reset on the second drain beat.
    capture(0, 3, rand_lanes());
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    for (int b = 0; b < 10 && !out_valid; b++) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("beat2_idx", {30'd0, out_idx}, 1);
    rn = 1'b0;
    #1;
    check_eq("arst_valid", {31'd0, out_valid}, 0);
    check_eq("arst_ready", {31'd0, cap_ready}, 0);
    tick();
    tick();
    rn = 1'b1;
    clear_model(1);
    #1;
    check_eq("rel_busy", {31'd0, busy}, 0);
    check_eq("rel_ready", {31'd0, cap_ready}, 1);
    check_eq("rel_err", {24'd0, err_cnt}, 0);
    drain(1, 0);

    // Randomized mix of captures, drains and run pulses.
    for (int it = 0; it < 200; it++) begin
      choice = $urandom_range(0, 19);
      if (choice < 15) begin
        capture($urandom_range(0, 7), $urandom_range(0, 3), rand_lanes());
      end else if (choice < 19) begin
        drain(1, 2);
      end else begin
        tick();
        tick();
        run = 1'b0;
        #1;
        check_eq("rnd_run0_ready", {31'd0, cap_ready}, 0);
        tick();
        run = 1'b1;
        clear_model(0);
      end
    end
    drain(1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
